bp_be_dcache_lce_cmd: RTL and testbench

- Dcache-side LCE command handler: receives CCE→LCE commands and turns them into dcache tag/data memory writes.
- Emits the wakeup pulses the LCE request FSM sleeps on: cce_data_received, uncached_data_received, set_tag_wakeup_received.
- Returns invalidate and sync acknowledgements to the CCE on its own LCE response port; arbitration with the request FSM's coh-ack happens outside this block.

---
 rtl/bp_be_dcache_lce_cmd.sv | 202 ++++++++++++++++++++
 tb/tb_bp_be_dcache_lce_cmd.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_be_dcache_lce_cmd.sv
// Dcache-side LCE command handler: turns CCE->LCE commands into tag/data memory
// writes, wakeup pulses for the LCE request FSM, and inv/sync acknowledgements.
module bp_be_dcache_lce_cmd #(
    parameter int paddr_width_p       = 32,
    parameter int lce_assoc_p         = 8,
    parameter int lce_sets_p          = 128,
    parameter int cce_block_width_p   = 512,
    parameter int lce_id_width_p      = 2,
    parameter int cce_id_width_p      = 2,
    parameter int timeout_max_limit_p = 4,
    localparam int block_offset_lp       = $clog2(cce_block_width_p / 8),
    localparam int index_width_lp        = $clog2(lce_sets_p),
    localparam int tag_width_lp          = paddr_width_p - block_offset_lp - index_width_lp,
    localparam int way_width_lp          = $clog2(lce_assoc_p),
    localparam int coh_width_lp          = 3,
    localparam int cmd_type_width_lp     = 4,
    localparam int resp_type_width_lp    = 2,
    localparam int lce_cce_cmd_width_lp  = cmd_type_width_lp + lce_id_width_p + cce_id_width_p
                                         + paddr_width_p + way_width_lp + coh_width_lp + cce_block_width_p,
    localparam int tag_mem_pkt_width_lp  = index_width_lp + way_width_lp + tag_width_lp + coh_width_lp + 1,
    localparam int data_mem_pkt_width_lp = index_width_lp + way_width_lp + cce_block_width_p + 1,
    localparam int lce_cce_resp_width_lp = resp_type_width_lp + cce_id_width_p + lce_id_width_p + paddr_width_p + 2,
    localparam int count_width_lp        = $clog2(timeout_max_limit_p + 1)
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [lce_id_width_p-1:0]        lce_id_i,
    input  logic [lce_cce_cmd_width_lp-1:0]  lce_cmd_i,
    input  logic                             lce_cmd_v_i,
    output logic                             lce_cmd_yumi_o,
    output logic [tag_mem_pkt_width_lp-1:0]  tag_mem_pkt_o,
    output logic                             tag_mem_pkt_v_o,
    input  logic                             tag_mem_pkt_yumi_i,
    output logic [data_mem_pkt_width_lp-1:0] data_mem_pkt_o,
    output logic                             data_mem_pkt_v_o,
    input  logic                             data_mem_pkt_yumi_i,
    output logic [lce_cce_resp_width_lp-1:0] lce_resp_o,
    output logic                             lce_resp_v_o,
    input  logic                             lce_resp_ready_i,
    output logic                             cce_data_received_o,
    output logic                             uncached_data_received_o,
    output logic                             set_tag_wakeup_received_o,
    output logic                             coherence_blocked_o,
    output logic                             coherence_timeout_o
);

    localparam logic [cmd_type_width_lp-1:0]  e_cmd_sync           = 4'd0;
    localparam logic [cmd_type_width_lp-1:0]  e_cmd_set_tag        = 4'd4;
    localparam logic [cmd_type_width_lp-1:0]  e_cmd_set_tag_wakeup = 4'd5;
    localparam logic [cmd_type_width_lp-1:0]  e_cmd_inv            = 4'd6;
    localparam logic [cmd_type_width_lp-1:0]  e_cmd_data           = 4'd8;
    localparam logic [cmd_type_width_lp-1:0]  e_cmd_uc_data        = 4'd9;
    localparam logic [resp_type_width_lp-1:0] e_resp_inv_ack      = 2'd0;
    localparam logic [resp_type_width_lp-1:0] e_resp_sync_ack     = 2'd1;

    localparam int state_lsb_lp = cce_block_width_p;
    localparam int way_lsb_lp   = state_lsb_lp + coh_width_lp;
    localparam int addr_lsb_lp  = way_lsb_lp + way_width_lp;
    localparam int ids_lsb_lp   = addr_lsb_lp + paddr_width_p;
    localparam int type_lsb_lp  = ids_lsb_lp + cce_id_width_p + lce_id_width_p;

    typedef enum logic [1:0] {e_READY, e_TAG, e_DATA, e_RESP} state_e;

    state_e                            state_r, state_n_s;
    logic [cmd_type_width_lp-1:0]      msg_type_r;
    logic [paddr_width_p-1:0]          addr_r;
    logic [way_width_lp-1:0]           way_r;
    logic [coh_width_lp-1:0]           coh_r;
    logic [cce_block_width_p-1:0]      data_r;
    logic [count_width_lp-1:0]         blocked_cnt_r;
    logic                              cce_data_received_r;
    logic                              uncached_data_received_r;
    logic                              set_tag_wakeup_received_r;
    logic [cmd_type_width_lp-1:0]      cmd_type_s;
    logic [index_width_lp-1:0]         index_s;
    logic [tag_width_lp-1:0]           tag_s;
    logic [cce_id_width_p-1:0]         cce_id_s;
    logic                              unused_s;

    assign cmd_type_s = lce_cmd_i[type_lsb_lp +: cmd_type_width_lp];
    // The command's own src/dst IDs carry no information this block acts on.
    assign unused_s   = ^lce_cmd_i[ids_lsb_lp +: (cce_id_width_p + lce_id_width_p)];

    assign index_s  = addr_r[block_offset_lp +: index_width_lp];
    assign tag_s    = addr_r[paddr_width_p-1 -: tag_width_lp];
    // Home CCE is chosen by block-interleaving on the low index bits.
    assign cce_id_s = addr_r[block_offset_lp +: cce_id_width_p];

    assign tag_mem_pkt_o  = {index_s, way_r, tag_s, coh_r, (msg_type_r == e_cmd_inv)};
    assign data_mem_pkt_o = {index_s, way_r, data_r, (msg_type_r == e_cmd_uc_data)};
    assign lce_resp_o     = {((msg_type_r == e_cmd_inv) ? e_resp_inv_ack : e_resp_sync_ack),
                             cce_id_s, lce_id_i, addr_r, 2'b00};

    assign coherence_blocked_o = (tag_mem_pkt_v_o & ~tag_mem_pkt_yumi_i)
                               | (data_mem_pkt_v_o & ~data_mem_pkt_yumi_i);
    assign coherence_timeout_o = (blocked_cnt_r == count_width_lp'(timeout_max_limit_p));

    assign cce_data_received_o       = cce_data_received_r;
    assign uncached_data_received_o  = uncached_data_received_r;
    assign set_tag_wakeup_received_o = set_tag_wakeup_received_r;

    // Next-state decode, command acceptance and memory/response valids.
    always_comb begin
        state_n_s        = state_r;
        lce_cmd_yumi_o   = 1'b0;
        tag_mem_pkt_v_o  = 1'b0;
        data_mem_pkt_v_o = 1'b0;
        lce_resp_v_o     = 1'b0;
        case (state_r)
            e_READY: begin
                if (lce_cmd_v_i) begin
                    lce_cmd_yumi_o = 1'b1;
                    case (cmd_type_s)
                        e_cmd_set_tag, e_cmd_set_tag_wakeup, e_cmd_inv: state_n_s = e_TAG;
                        e_cmd_data, e_cmd_uc_data:                       state_n_s = e_DATA;
                        e_cmd_sync:                                      state_n_s = e_RESP;
                        default:                                         state_n_s = e_READY;
                    endcase
                end else begin
                    state_n_s = e_READY;
                end
            end
            e_TAG: begin
                tag_mem_pkt_v_o = 1'b1;
                if (tag_mem_pkt_yumi_i) begin
                    state_n_s = (msg_type_r == e_cmd_inv) ? e_RESP : e_READY;
                end else begin
                    state_n_s = e_TAG;
                end
            end
            e_DATA: begin
                data_mem_pkt_v_o = 1'b1;
                if (data_mem_pkt_yumi_i) begin
                    state_n_s = e_READY;
                end else begin
                    state_n_s = e_DATA;
                end
            end
            e_RESP: begin
                lce_resp_v_o = 1'b1;
                if (lce_resp_ready_i) begin
                    state_n_s = e_READY;
                end else begin
                    state_n_s = e_RESP;
                end
            end
            default: state_n_s = e_READY;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= e_READY;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Command header/data capture on acceptance.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            msg_type_r <= '0;
            addr_r     <= '0;
            way_r      <= '0;
            coh_r      <= '0;
            data_r     <= '0;
        end else if (lce_cmd_yumi_o) begin
            msg_type_r <= cmd_type_s;
            addr_r     <= lce_cmd_i[addr_lsb_lp +: paddr_width_p];
            way_r      <= lce_cmd_i[way_lsb_lp +: way_width_lp];
            coh_r      <= lce_cmd_i[state_lsb_lp +: coh_width_lp];
            data_r     <= lce_cmd_i[0 +: cce_block_width_p];
        end
    end

    // Wakeup pulses, one cycle after the completing memory write.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cce_data_received_r       <= 1'b0;
            uncached_data_received_r  <= 1'b0;
            set_tag_wakeup_received_r <= 1'b0;
        end else begin
            cce_data_received_r       <= (state_r == e_DATA) & data_mem_pkt_yumi_i & (msg_type_r == e_cmd_data);
            uncached_data_received_r  <= (state_r == e_DATA) & data_mem_pkt_yumi_i & (msg_type_r == e_cmd_uc_data);
            set_tag_wakeup_received_r <= (state_r == e_TAG) & tag_mem_pkt_yumi_i
                                       & (msg_type_r == e_cmd_set_tag_wakeup);
        end
    end

    // Saturating count of consecutive blocked cycles.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            blocked_cnt_r <= '0;
        end else if (!coherence_blocked_o) begin
            blocked_cnt_r <= '0;
        end else if (blocked_cnt_r != count_width_lp'(timeout_max_limit_p)) begin
            blocked_cnt_r <= blocked_cnt_r + count_width_lp'(1);
        end
    end

endmodule

// File: tb/tb_bp_be_dcache_lce_cmd.sv
// Scoreboard bench for bp_be_dcache_lce_cmd: directed plan items plus random
// commands checked against an arithmetic model of the expected packets.
module tb_bp_be_dcache_lce_cmd;
    localparam int CMDW = 558, TAGW = 33, DATAW = 523, RESPW = 40, LIMIT = 4;
    localparam logic [3:0] T_SYNC = 4'd0, T_SET_TAG = 4'd4, T_WAKE = 4'd5,
                           T_INV = 4'd6, T_DATA = 4'd8, T_UC = 4'd9;

    typedef struct packed { logic [TAGW-1:0]  pkt; logic [2:0] pulse; } tag_exp_t;
    typedef struct packed { logic [DATAW-1:0] pkt; logic [2:0] pulse; } data_exp_t;

    logic             clk_i = 1'b0;
    logic             reset_i;
    logic [1:0]       lce_id_i;
    logic [CMDW-1:0]  lce_cmd_i;
    logic             lce_cmd_v_i;
    logic             lce_cmd_yumi_o;
    logic [TAGW-1:0]  tag_mem_pkt_o;
    logic             tag_mem_pkt_v_o;
    logic             tag_mem_pkt_yumi_i;
    logic [DATAW-1:0] data_mem_pkt_o;
    logic             data_mem_pkt_v_o;
    logic             data_mem_pkt_yumi_i;
    logic [RESPW-1:0] lce_resp_o;
    logic             lce_resp_v_o;
    logic             lce_resp_ready_i;
    logic             cce_data_received_o, uncached_data_received_o, set_tag_wakeup_received_o;
    logic             coherence_blocked_o, coherence_timeout_o;

    bp_be_dcache_lce_cmd dut (
        .clk_i(clk_i), .reset_i(reset_i), .lce_id_i(lce_id_i),
        .lce_cmd_i(lce_cmd_i), .lce_cmd_v_i(lce_cmd_v_i), .lce_cmd_yumi_o(lce_cmd_yumi_o),
        .tag_mem_pkt_o(tag_mem_pkt_o), .tag_mem_pkt_v_o(tag_mem_pkt_v_o), .tag_mem_pkt_yumi_i(tag_mem_pkt_yumi_i),
        .data_mem_pkt_o(data_mem_pkt_o), .data_mem_pkt_v_o(data_mem_pkt_v_o), .data_mem_pkt_yumi_i(data_mem_pkt_yumi_i),
        .lce_resp_o(lce_resp_o), .lce_resp_v_o(lce_resp_v_o), .lce_resp_ready_i(lce_resp_ready_i),
        .cce_data_received_o(cce_data_received_o), .uncached_data_received_o(uncached_data_received_o),
        .set_tag_wakeup_received_o(set_tag_wakeup_received_o),
        .coherence_blocked_o(coherence_blocked_o), .coherence_timeout_o(coherence_timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0, n_errors = 0, n_sent = 0, n_yumi = 0;
    tag_exp_t         tag_q[$];
    data_exp_t        data_q[$];
    logic [RESPW-1:0] resp_q[$];
    int f_tag = -1, f_data = -1, f_resp = -1;

    task automatic chk(input string nm, input logic [DATAW-1:0] act, input logic [DATAW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: fields derived arithmetically from a 64-byte block, 128-set cache.
    function automatic logic [TAGW-1:0] exp_tag(input logic [3:0] t, input logic [31:0] a,
                                                input logic [2:0] w, input logic [2:0] s);
        logic [6:0]  idx;
        logic [18:0] tg;
        idx = 7'((a / 32'd64) % 32'd128);
        tg  = 19'(a / 32'd8192);
        return {idx, w, tg, s, (t == T_INV)};
    endfunction

    function automatic logic [DATAW-1:0] exp_data(input logic [3:0] t, input logic [31:0] a,
                                                  input logic [2:0] w, input logic [511:0] d);
        logic [6:0] idx;
        idx = 7'((a / 32'd64) % 32'd128);
        return {idx, w, d, (t == T_UC)};
    endfunction

    function automatic logic [RESPW-1:0] exp_resp(input logic [3:0] t, input logic [31:0] a);
        logic [1:0] cce;
        cce = 2'((a / 32'd64) % 32'd4);
        return {((t == T_INV) ? 2'd0 : 2'd1), cce, lce_id_i, a, 2'd0};
    endfunction

    task automatic send(input logic [3:0] t, input logic [31:0] a, input logic [2:0] w,
                        input logic [2:0] s, input logic [511:0] d, output int waited);
        case (t)
            T_SET_TAG: tag_q.push_back({exp_tag(t, a, w, s), 3'b000});
            T_WAKE:    tag_q.push_back({exp_tag(t, a, w, s), 3'b001});
            T_INV: begin
                tag_q.push_back({exp_tag(t, a, w, s), 3'b000});
                resp_q.push_back(exp_resp(t, a));
            end
            T_DATA:    data_q.push_back({exp_data(t, a, w, d), 3'b100});
            T_UC:      data_q.push_back({exp_data(t, a, w, d), 3'b010});
            T_SYNC:    resp_q.push_back(exp_resp(t, a));
            default: ;
        endcase
        lce_cmd_i   = {t, lce_id_i, 2'b01, a, w, s, d};
        lce_cmd_v_i = 1'b1;
        n_sent++;
        waited = 0;
        @(negedge clk_i);
        while (!lce_cmd_yumi_o && waited < 200) begin
            waited++;
            @(negedge clk_i);
        end
        if (!lce_cmd_yumi_o) chk("cmd_yumi_timeout", 1'b0, 1'b1);
        @(posedge clk_i);
        #1;
        lce_cmd_v_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Responder: accepts packets/responses after a forced or random number of cycles.
    initial begin
        int tw = 0, tt = 0, dw = 0, dt = 0, rw = 0, rt = 0;
        bit tb = 0, db = 0, rb = 0;
        tag_mem_pkt_yumi_i = 1'b0; data_mem_pkt_yumi_i = 1'b0; lce_resp_ready_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            if (reset_i || !tag_mem_pkt_v_o) begin tag_mem_pkt_yumi_i = 1'b0; tb = 0; end
            else begin
                if (!tb) begin tb = 1; tw = 0; tt = (f_tag >= 0) ? f_tag : int'($urandom_range(0, 3)); end
                tag_mem_pkt_yumi_i = (tw >= tt);
                if (tag_mem_pkt_yumi_i) tb = 0; else tw++;
            end
            if (reset_i || !data_mem_pkt_v_o) begin data_mem_pkt_yumi_i = 1'b0; db = 0; end
            else begin
                if (!db) begin db = 1; dw = 0; dt = (f_data >= 0) ? f_data : int'($urandom_range(0, 3)); end
                data_mem_pkt_yumi_i = (dw >= dt);
                if (data_mem_pkt_yumi_i) db = 0; else dw++;
            end
            if (reset_i || !lce_resp_v_o) begin lce_resp_ready_i = 1'b0; rb = 0; end
            else begin
                if (!rb) begin rb = 1; rw = 0; rt = (f_resp >= 0) ? f_resp : int'($urandom_range(0, 3)); end
                lce_resp_ready_i = (rw >= rt);
                if (lce_resp_ready_i) rb = 0; else rw++;
            end
        end
    end

    // Monitor: pops the scoreboard on each handshake and checks stability, pulses and blocking.
    logic [2:0]       pend_pulse = 3'b000;
    int               consec = 0;
    bit               tag_hold = 0, data_hold = 0, resp_hold = 0;
    logic [TAGW-1:0]  tag_prev;
    logic [DATAW-1:0] data_prev;
    logic [RESPW-1:0] resp_prev;
    always @(negedge clk_i) begin
        tag_exp_t  te;
        data_exp_t de;
        logic      blk;
        if (reset_i) begin
            pend_pulse = 3'b000; consec = 0; tag_hold = 0; data_hold = 0; resp_hold = 0;
        end else begin
            if (lce_cmd_yumi_o) begin
                n_yumi++;
                chk("yumi_while_busy", {tag_mem_pkt_v_o, data_mem_pkt_v_o, lce_resp_v_o}, 3'b000);
            end
            chk("pulses", {cce_data_received_o, uncached_data_received_o, set_tag_wakeup_received_o}, pend_pulse);
            pend_pulse = 3'b000;
            if (tag_hold) chk("tag_stable", {tag_mem_pkt_v_o, tag_mem_pkt_o}, {1'b1, tag_prev});
            if (data_hold) chk("data_stable", {data_mem_pkt_v_o, data_mem_pkt_o}, {1'b1, data_prev});
            if (resp_hold) chk("resp_stable", {lce_resp_v_o, lce_resp_o}, {1'b1, resp_prev});
            if (tag_mem_pkt_v_o && tag_mem_pkt_yumi_i) begin
                if (tag_q.size() == 0) chk("tag_unexpected", 1'b1, 1'b0);
                else begin te = tag_q.pop_front(); chk("tag_pkt", tag_mem_pkt_o, te.pkt); pend_pulse |= te.pulse; end
            end
            if (data_mem_pkt_v_o && data_mem_pkt_yumi_i) begin
                if (data_q.size() == 0) chk("data_unexpected", 1'b1, 1'b0);
                else begin de = data_q.pop_front(); chk("data_pkt", data_mem_pkt_o, de.pkt); pend_pulse |= de.pulse; end
            end
            if (lce_resp_v_o && lce_resp_ready_i) begin
                if (resp_q.size() == 0) chk("resp_unexpected", 1'b1, 1'b0);
                else chk("resp", lce_resp_o, resp_q.pop_front());
            end
            blk = (tag_mem_pkt_v_o && !tag_mem_pkt_yumi_i) || (data_mem_pkt_v_o && !data_mem_pkt_yumi_i);
            chk("blocked", coherence_blocked_o, blk);
            chk("timeout", coherence_timeout_o, (consec >= LIMIT));
            consec    = blk ? consec + 1 : 0;
            tag_hold  = tag_mem_pkt_v_o && !tag_mem_pkt_yumi_i;
            data_hold = data_mem_pkt_v_o && !data_mem_pkt_yumi_i;
            resp_hold = lce_resp_v_o && !lce_resp_ready_i;
            tag_prev  = tag_mem_pkt_o; data_prev = data_mem_pkt_o; resp_prev = lce_resp_o;
        end
    end

    task automatic drain();
        int n = 0;
        while ((tag_q.size() + data_q.size() + resp_q.size()) != 0 && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        chk("queues_drained", 32'(tag_q.size() + data_q.size() + resp_q.size()), 32'd0);
    endtask

    initial begin
        int w, w2;
        logic [3:0]   t;
        logic [511:0] d;
        reset_i = 1'b1; lce_cmd_v_i = 1'b0; lce_cmd_i = '0; lce_id_i = 2'd2;
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_valids", {lce_cmd_yumi_o, tag_mem_pkt_v_o, data_mem_pkt_v_o, lce_resp_v_o}, 4'b0000);
        reset_i = 1'b0;
        @(negedge clk_i);
        chk("post_reset_pulses", {cce_data_received_o, uncached_data_received_o, set_tag_wakeup_received_o}, 3'b000);
        chk("post_reset_block", {coherence_blocked_o, coherence_timeout_o}, 2'b00);
        idle(1);

        // set_tag_wakeup with immediate yumi
        f_tag = 0;
        send(T_WAKE, 32'h8000_1040, 3'd3, 3'd2, '0, w);
        idle(3);
        // data with yumi withheld 6 cycles
        f_data = 6;
        d = {128{4'hA, 4'h5}};
        send(T_DATA, 32'h8000_3080, 3'd1, 3'd1, d, w);
        idle(10);
        // invalidate with response ready withheld 3 cycles
        f_resp = 3;
        send(T_INV, 32'h8000_2000, 3'd5, 3'd0, '0, w);
        idle(8);
        // uc_data then sync back-to-back
        f_data = 0; f_resp = 0;
        send(T_UC, 32'h1234_5678, 3'd6, 3'd1, {16{32'hDEAD_BEEF}}, w);
        send(T_SYNC, 32'h0000_00C0, 3'd0, 3'd0, '0, w2);
        chk("b2b_second_yumi_wait", 32'(w2), 32'd1);
        idle(4);
        // unknown message type
        send(4'd3, 32'hFFFF_FFC0, 3'd7, 3'd7, '1, w);
        chk("unknown_yumi_wait", 32'(w), 32'd0);
        idle(3);
        drain();

        // randomized phase
        f_tag = -1; f_data = -1; f_resp = -1;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 11))
                0: t = T_SYNC;  1: t = T_SET_TAG; 2: t = T_WAKE; 3: t = T_INV;
                4: t = T_DATA;  5: t = T_UC;      6: t = T_DATA; 7: t = T_INV;
                8: t = 4'd1;    9: t = 4'd7;      10: t = 4'd10; default: t = 4'd15;
            endcase
            for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
            send(t, $urandom, 3'($urandom), 3'($urandom), d, w);
            if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 3));
        end
        drain();
        idle(2);
        chk("yumi_count", 32'(n_yumi), 32'(n_sent));

        // asynchronous reset while a data write is pending
        f_data = 50;
        send(T_DATA, 32'h8000_4000, 3'd2, 3'd1, {16{32'hCAFE_F00D}}, w);
        @(negedge clk_i);
        chk("data_pending_before_reset", data_mem_pkt_v_o, 1'b1);
        #2;
        reset_i = 1'b1;
        #1;
        chk("data_v_async_drop", data_mem_pkt_v_o, 1'b0);
        data_q.delete();
        idle(2);
        reset_i = 1'b0;
        f_data = -1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("after_reset_quiet", {tag_mem_pkt_v_o, data_mem_pkt_v_o, lce_resp_v_o, cce_data_received_o,
                                      uncached_data_received_o, set_tag_wakeup_received_o}, 6'b000000);
        end
        idle(1);
        send(T_SET_TAG, 32'h8000_5140, 3'd4, 3'd3, '0, w);
        chk("ready_after_reset", 32'(w), 32'd0);
        drain();
        idle(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
